// File: rtl/sram_pkg.sv
// Shared definitions for the external-SRAM data-memory controller.
// Holds the controller state encoding, SRAM bus widths and the default
// byte address that maps onto SRAM word 0.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    // Phase counter width; covers the legal ACCESS_CYCLES range 2..15.
    localparam int CNT_W = 4;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_phase_timer.sv
// Phase timer for one 16-bit SRAM access phase.
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   load_i       restart the count at 0 (entering a phase)
//   en_i         advance the count by one
//   last_cycle_o count is on the final cycle of the phase
//   penult_o     count is on the cycle before the final one
module sram_phase_timer
    import sram_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic last_cycle_o,
    output logic penult_o
);

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] PENULT_CNT = CNT_W'(ACCESS_CYCLES - 2);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign last_cycle_o = (cnt_q == LAST_CNT);
    assign penult_o     = (cnt_q == PENULT_CNT);

endmodule

// File: rtl/sram_controller.sv
// Data-memory responder that serves 32-bit word requests from the memory
// stage as two 16-bit accesses (low half, then high half) to an external
// asynchronous SRAM. ready drops while a transaction is in flight so the
// pipeline can freeze on ~ready.
// Ports:
//   clk, rst (async, active-low)
//   rd_en, wr_en, address, write_data   request from the memory stage
//   read_data, ready                    registered load result / handshake
//   sram_addr, sram_we_n, sram_dq_out,
//   sram_dq_oe, sram_dq_in              SRAM pins (tristate built above)
module sram_controller
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in
);

    state_e                 state_q;
    logic                   is_wr_q;
    logic [SRAM_ADDR_W-2:0] word_q;
    logic [31:0]            wdata_q;

    logic        req;
    logic [31:0] offset;
    logic        last_cycle;
    logic        penult;
    logic        tmr_load;
    logic        tmr_en;
    logic        unused_offset_bits;

    assign req    = rd_en | wr_en;
    // 32-bit subtraction wraps, so addresses below BASE_ADDR land at the top of the SRAM.
    assign offset = address - BASE_ADDR;
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    assign tmr_load = ((state_q == IDLE) && req) || ((state_q == LOW) && last_cycle);
    assign tmr_en   = ((state_q == LOW) || (state_q == HIGH)) && !last_cycle;

    sram_phase_timer #(
        .ACCESS_CYCLES (ACCESS_CYCLES)
    ) u_timer (
        .clk_i        (clk),
        .rst_ni       (rst),
        .load_i       (tmr_load),
        .en_i         (tmr_en),
        .last_cycle_o (last_cycle),
        .penult_o     (penult)
    );

    assign ready = ((state_q == IDLE) && !req) || (state_q == DONE);

    // SRAM pins are registered and take each phase's values on the edge that
    // enters the phase. The write strobe is released one cycle early in every
    // phase so the address is stable on both sides of each strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        // A simultaneous read and write is served as a write.
                        is_wr_q     <= wr_en;
                        word_q      <= offset[18:2];
                        wdata_q     <= write_data;
                        state_q     <= LOW;
                        sram_addr   <= {offset[18:2], 1'b0};
                        sram_dq_out <= write_data[15:0];
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= !wr_en;
                    end
                end
                LOW: begin
                    if (last_cycle) begin
                        state_q     <= HIGH;
                        sram_addr   <= {word_q, 1'b1};
                        sram_dq_out <= wdata_q[31:16];
                        sram_we_n   <= !is_wr_q;
                        if (!is_wr_q) begin
                            read_data[15:0] <= sram_dq_in;
                        end
                    end else if (penult) begin
                        sram_we_n <= 1'b1;
                    end
                end
                HIGH: begin
                    if (last_cycle) begin
                        state_q    <= DONE;
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        if (!is_wr_q) begin
                            read_data[31:16] <= sram_dq_in;
                        end
                    end else if (penult) begin
                        sram_we_n <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] mem [0:262143];

    logic        tr_rdy [0:5];
    logic [17:0] tr_addr[0:5];
    logic        tr_we  [0:5];
    logic        tr_oe  [0:5];
    logic [15:0] tr_dq  [0:5];
    logic [31:0] tr_rd  [0:5];

    sram_controller #(
        .BASE_ADDR     (32'd1024),
        .ACCESS_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_we_n   (sram_we_n),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM: combinational read, write sampled mid-cycle while strobed.
    assign sram_dq_in = mem[sram_addr];
    always @(negedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr] = sram_dq_out;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Starts at posedge+1; records cycles 0..5 at negedges; ends at posedge+1.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input bit clr);
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tr_rdy[k]  = ready;
            tr_addr[k] = sram_addr;
            tr_we[k]   = sram_we_n;
            tr_oe[k]   = sram_dq_oe;
            tr_dq[k]   = sram_dq_out;
            tr_rd[k]   = read_data;
        end
        @(posedge clk);
        #1;
        if (clr) begin
            rd_en = 1'b0; wr_en = 1'b0;
        end
    endtask

    task automatic check_wr(input string nm, input logic [17:0] a0, input logic [31:0] d);
        for (int k = 0; k < 6; k++)
            chk($sformatf("%s c%0d ready", nm, k), 32'(tr_rdy[k]), 32'(k == 5));
        chk({nm, " c1 addr"}, 32'(tr_addr[1]), 32'(a0));
        chk({nm, " c2 addr"}, 32'(tr_addr[2]), 32'(a0));
        chk({nm, " c3 addr"}, 32'(tr_addr[3]), 32'(a0 | 18'd1));
        chk({nm, " c4 addr"}, 32'(tr_addr[4]), 32'(a0 | 18'd1));
        chk({nm, " c1 we_n"}, 32'(tr_we[1]), 32'd0);
        chk({nm, " c2 we_n"}, 32'(tr_we[2]), 32'd1);
        chk({nm, " c3 we_n"}, 32'(tr_we[3]), 32'd0);
        chk({nm, " c4 we_n"}, 32'(tr_we[4]), 32'd1);
        chk({nm, " c5 we_n"}, 32'(tr_we[5]), 32'd1);
        for (int k = 1; k < 5; k++)
            chk($sformatf("%s c%0d oe", nm, k), 32'(tr_oe[k]), 32'd1);
        chk({nm, " c5 oe"}, 32'(tr_oe[5]), 32'd0);
        chk({nm, " c1 dq"}, 32'(tr_dq[1]), 32'(d[15:0]));
        chk({nm, " c3 dq"}, 32'(tr_dq[3]), 32'(d[31:16]));
    endtask

    task automatic check_rd(input string nm, input logic [17:0] a0, input logic [31:0] d);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("%s c%0d ready", nm, k), 32'(tr_rdy[k]), 32'(k == 5));
            chk($sformatf("%s c%0d we_n", nm, k), 32'(tr_we[k]), 32'd1);
            chk($sformatf("%s c%0d oe", nm, k), 32'(tr_oe[k]), 32'd0);
        end
        chk({nm, " c1 addr"}, 32'(tr_addr[1]), 32'(a0));
        chk({nm, " c3 addr"}, 32'(tr_addr[3]), 32'(a0 | 18'd1));
        chk({nm, " c5 read_data"}, tr_rd[5], d);
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        #2 rst = 1'b0;
        #1;
        chk("rst ready",     32'(ready), 32'd1);
        chk("rst read_data", read_data, 32'd0);
        chk("rst addr",      32'(sram_addr), 32'd0);
        chk("rst we_n",      32'(sram_we_n), 32'd1);
        chk("rst oe",        32'(sram_dq_oe), 32'd0);
        chk("rst dq",        32'(sram_dq_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Write 1028 -> SRAM words 2,3
        run_txn(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b1);
        check_wr("wr1028", 18'd2, 32'hDEADBEEF);
        chk("mem[2]", 32'(mem[2]), 32'h0000BEEF);
        chk("mem[3]", 32'(mem[3]), 32'h0000DEAD);

        // Read back
        run_txn(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1);
        check_rd("rd1028", 18'd2, 32'hDEADBEEF);

        // Simultaneous read+write: write wins, read_data untouched
        run_txn(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b1);
        check_wr("rw1024", 18'd0, 32'h12345678);
        chk("mem[0]", 32'(mem[0]), 32'h00005678);
        chk("mem[1]", 32'(mem[1]), 32'h00001234);
        chk("rw1024 read_data held", tr_rd[5], 32'hDEADBEEF);

        // Back-to-back write then read of 1032
        run_txn(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b0);
        check_wr("b2b wr", 18'd4, 32'hCAFEF00D);
        run_txn(1'b1, 1'b0, 32'd1032, 32'h0, 1'b1);
        check_rd("b2b rd", 18'd4, 32'hCAFEF00D);

        // Wrap: 1020 -> offset 0xFFFFFFFC
        run_txn(1'b0, 1'b1, 32'd1020, 32'hA5A55A5A, 1'b1);
        check_wr("wrap wr", 18'h3FFFE, 32'hA5A55A5A);
        chk("mem[3FFFE]", 32'(mem[18'h3FFFE]), 32'h00005A5A);
        chk("mem[3FFFF]", 32'(mem[18'h3FFFF]), 32'h0000A5A5);
        run_txn(1'b1, 1'b0, 32'd1020, 32'h0, 1'b1);
        check_rd("wrap rd", 18'h3FFFE, 32'hA5A55A5A);

        // Reset in the HIGH phase of a write to 1040 (words 8,9)
        wr_en = 1'b1; address = 32'd1040; write_data = 32'h11112222;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0;
        #1;
        chk("midrst we_n",      32'(sram_we_n), 32'd1);
        chk("midrst oe",        32'(sram_dq_oe), 32'd0);
        chk("midrst ready",     32'(ready), 32'd1);
        chk("midrst read_data", read_data, 32'd0);
        chk("midrst addr",      32'(sram_addr), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst mem[8]", 32'(mem[8]), 32'h00002222);
        chk("midrst mem[9]", 32'(mem[9]), 32'h00000000);
        chk("midrst idle ready", 32'(ready), 32'd1);
        chk("midrst idle we_n",  32'(sram_we_n), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Responder end of the data-memory interface driven by the pipeline's memory stage.
- Accepts 32-bit word read/write requests and serves each as two 16-bit accesses to an external asynchronous SRAM (low half first).
- Deasserts ready while busy; the top level ORs ~ready into the pipeline freeze.
- Replaces the on-chip data memory behind the EXE/MEM register.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0; subtracted from every request address.
- ACCESS_CYCLES, 2: clocks per 16-bit SRAM access phase; legal range 2..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rd_en  in  1  read request from memory stage.
- wr_en  in  1  write request from memory stage.
- address  in  32  byte address, word aligned.
- write_data  in  32  store value.
- read_data  out  32  registered load result.
- ready  out  1  1 = no pending work / result valid; 0 = freeze pipeline.
- sram_addr  out  18  SRAM half-word address.
- sram_we_n  out  1  SRAM write strobe, active-low.
- sram_dq_out  out  16  data driven to SRAM.
- sram_dq_oe  out  1  1 = drive sram_dq_out onto bus; top level builds the tristate.
- sram_dq_in  in  16  data sampled from SRAM bus.

Behaviour:
- Reset while rst=0, asynchronous, any state:
  - state=IDLE, counter=0, read_data=0, sram_addr=0, sram_we_n=1, sram_dq_out=0, sram_dq_oe=0.
  - A reset mid-transaction aborts it; no partial write is repeated afterwards.
- Address mapping: offset=address-BASE_ADDR (32-bit, wraps); word=offset[18:2]; sram_addr={word[16:0],half}, half=0 for LOW, 1 for HIGH. offset[1:0] ignored.
- FSM states:
  - IDLE: if rd_en|wr_en, latch op, mapped address and write_data; go to LOW. If both are asserted, the write wins.
  - LOW: ACCESS_CYCLES clocks; half=0; write data = write_data[15:0].
  - HIGH: ACCESS_CYCLES clocks; half=1; write data = write_data[31:16].
  - DONE: one clock, then IDLE.
- Counter: reloads 0 on entering a phase. Phase ends when counter==ACCESS_CYCLES-1.
- SRAM outputs are registered. They take their phase values on the edge entering the phase.
- Writes:
  - sram_dq_oe=1 for the whole of LOW and HIGH.
  - sram_we_n=0 on all but the last cycle of each phase, giving two separate strobes with the address stable around each.
- Reads:
  - sram_dq_oe=0 and sram_we_n=1 throughout.
  - read_data[15:0] captured from sram_dq_in on the edge leaving LOW.
  - read_data[31:16] captured on the edge leaving HIGH.
  - read_data holds until the next read completes; writes do not alter it.
- ready (combinational) = (state==IDLE && !(rd_en|wr_en)) || state==DONE.
- Latency: request seen at cycle 0; ready=0 for cycles 0..2*ACCESS_CYCLES; ready=1 at cycle 2*ACCESS_CYCLES+1 (DONE) with read_data valid.
- Back-to-back: a request still asserted in the cycle after DONE is treated as new. The pipeline has advanced by then, so this is the next instruction.
- Request dropped mid-transaction (flush): the transaction still completes; write side effects are not cancelled.
- Outside IDLE, the address and data ports are ignored (latched copy used).

Decomposition:
- Shared package sram_pkg:
  - state enum {IDLE, LOW, HIGH, DONE};
  - SRAM_ADDR_W=18, SRAM_DATA_W=16;
  - default BASE_ADDR.
- One natural sub-module, sram_phase_timer: counter with load/enable, outputs last_cycle. The FSM, latches and output registers stay in sram_controller.

Test Plan:
- Reset mid-write: pulse rst low in HIGH of a write -> sram_we_n=1, sram_dq_oe=0, ready=1 immediately; the SRAM model shows only the low half written.
- Write, ACCESS_CYCLES=2: wr_en, address=1028, write_data=0xDEADBEEF -> sram_addr=2 with dq 0xBEEF, then sram_addr=3 with dq 0xDEAD; one we_n low cycle per half; ready low for cycles 0..4, high at cycle 5.
- Read back: rd_en, address=1028 -> read_data=0xDEADBEEF at cycle 5 with ready=1; sram_dq_oe stays 0.
- Simultaneous rd_en=wr_en=1, address=1024, write_data=0x12345678 -> write performed (SRAM words 0,1 = 0x5678,0x1234); read_data unchanged.
- Back-to-back: write to 1032, then read of 1032 asserted in the cycle after DONE -> second transaction starts that cycle; read_data equals the written value.
- Wrap: address=1020 (offset 0xFFFFFFFC) -> sram_addr=0x3FFFE then 0x3FFFF; completes normally.
